cic_interp_mc: RTL
==================

CIC_INTERP_MC -- requirements
Module: cic_interp_mc

Interface
Parameters (name, default, meaning):
REQ-001 IN_WIDTH, 16: signed sample width per channel.
REQ-002 OUT_WIDTH, 16: signed output width per channel.
REQ-003 STAGES, 4: number of comb stages and of integrator stages, legal range 1..6.
REQ-004 CHANNELS, 2: number of independent datapaths sharing one rate counter, legal range 1..4.
REQ-005 MAX_RATE_LOG2, 7: log2 of the largest interpolation rate; internal width ACC_WIDTH = IN_WIDTH + STAGES*MAX_RATE_LOG2.

Ports (name, direction, width, meaning):
REQ-006 clock, in, 1: single clock; all logic is on its rising edge.
REQ-007 reset, in, 1: synchronous, active-high reset.
REQ-008 enable, in, 1: run when high; when low, state clears synchronously as for reset.
REQ-009 rate, in, 8: interpolation ratio R; 0 and 1 both mean 1.
REQ-010 shift, in, 6: arithmetic right shift applied to the final integrator, range 0..ACC_WIDTH-1.
REQ-011 signal_in, in, CHANNELS*IN_WIDTH: packed samples, channel 0 in the LSBs.
REQ-012 strobe_in, out, 1: sample request; signal_in is captured in the cycle this is high.
REQ-013 signal_out, out, CHANNELS*OUT_WIDTH: packed registered outputs.
REQ-014 strobe_out, out, 1: output valid.

Function
REQ-015 The rate counter SHALL behave as follows: 0 on reset or when enable is low; reload to max(rate,1)-1 when at 0; otherwise decrement by 1.
REQ-016 rate SHALL be sampled only at reload, so a mid-period change takes effect at the next period.
REQ-017 strobe_in SHALL equal enable AND (counter==0).
REQ-018 With rate<=1, strobe_in SHALL be high every enabled cycle.
REQ-019 Each channel SHALL be a STAGES-deep comb chain (y = x - x delayed by one strobe), sign-extended to ACC_WIDTH, with delay registers advancing only on strobe_in; the comb result is registered into comb_reg on strobe_in.
REQ-020 The integrator input SHALL be comb_reg in the cycle immediately after strobe_in and 0 in all other cycles (zero-stuffing).
REQ-021 STAGES registered integrators SHALL update every enabled cycle, wrapping modulo 2^ACC_WIDTH.
REQ-022 Output path: last integrator arithmetically shifted right by shift, saturated to the signed OUT_WIDTH range, then registered into signal_out.
REQ-023 Latency: a sample captured in strobe cycle T SHALL first affect signal_out in cycle T+STAGES+2.
REQ-024 DC gain before shift SHALL be R^(STAGES-1).
REQ-025 strobe_out SHALL be high on every cycle once enable has been continuously high for STAGES+2 cycles, and low otherwise.
REQ-026 Channels SHALL be bit-independent: no cross-channel effect.

Reset
REQ-027 On reset: counter, all comb delays, comb_reg, integrators, signal_out and the strobe_out qualifier counter SHALL be 0; strobe_in and strobe_out SHALL be 0 in the following cycle.
REQ-028 reset SHALL take priority over enable.
REQ-029 Reset or enable low asserted mid-period SHALL discard all in-flight samples.

Configuration
REQ-030 Macro CIC_INTERP_ROUND_EN defined: when shift>0, add 2^(shift-1) before shifting (round half up).
REQ-031 Macro CIC_INTERP_ROUND_EN undefined: truncation (floor).
REQ-032 Saturation SHALL apply after rounding in both builds.

Verification
REQ-033 Reset: hold reset 5 cycles with enable=1 -> signal_out=0, strobe_in=0, strobe_out=0 throughout; first strobe_in in the first cycle after release.
REQ-034 DC: STAGES=4, rate=32, shift=0, all channels in=1 -> strobe_in period 32 clocks; signal_out settles to 32768 (OUT_WIDTH=24 build); strobe_out high from cycle 6 after enable.
REQ-035 Impulse: STAGES=2, rate=2, shift=0, in=1 for one strobe then 0 -> outputs 1,2,1,0 starting STAGES+2 cycles after the capturing strobe; other channel fed 0 stays 0.
REQ-036 Saturation: OUT_WIDTH=16, rate=32, STAGES=4, shift=0, in=+32767 -> output 32767; in=-32768 -> output -32768.
REQ-037 Rounding: STAGES=2, rate=4, shift=3; in=1 -> output 1 with macro, 0 without; in=-1 -> 0 with macro, -1 without.
REQ-038 Rate change and enable drop: change rate 8->3 mid-period -> current period stays 8 clocks and the next is 3; drop enable for 1 cycle -> all state 0 and strobe_out low for STAGES+2 cycles.

Source files
------------

// File: rtl/cic_interp_mc.sv
// Multichannel CIC interpolator: STAGES combs at the input rate, zero-stuffing, STAGES integrators at clock rate.
// Optional macro CIC_INTERP_ROUND_EN selects round-half-up on the output shift; otherwise the shift truncates.
module cic_interp_mc #(
  parameter int IN_WIDTH      = 16,
  parameter int OUT_WIDTH     = 16,
  parameter int STAGES        = 4,
  parameter int CHANNELS      = 2,
  parameter int MAX_RATE_LOG2 = 7
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [7:0]                    rate,
  input  logic [5:0]                    shift,
  input  logic [CHANNELS*IN_WIDTH-1:0]  signal_in,
  output logic                          strobe_in,
  output logic [CHANNELS*OUT_WIDTH-1:0] signal_out,
  output logic                          strobe_out
);

  localparam int ACC_WIDTH = IN_WIDTH + STAGES * MAX_RATE_LOG2;
  localparam int EXT_WIDTH = ACC_WIDTH + 1;
  localparam int QUAL_MAX  = STAGES + 2;
  localparam int QUAL_W    = $clog2(QUAL_MAX + 1);

  localparam logic signed [EXT_WIDTH-1:0] SAT_HI = EXT_WIDTH'({(OUT_WIDTH-1){1'b1}});
  localparam logic signed [EXT_WIDTH-1:0] SAT_LO = ~SAT_HI;

  if (STAGES < 1 || STAGES > 6) begin : g_bad_stages
    $error("cic_interp_mc: STAGES must be in 1..6");
  end
  if (CHANNELS < 1 || CHANNELS > 4) begin : g_bad_channels
    $error("cic_interp_mc: CHANNELS must be in 1..4");
  end
  if (OUT_WIDTH > ACC_WIDTH) begin : g_bad_out_width
    $error("cic_interp_mc: OUT_WIDTH must not exceed the accumulator width");
  end

  logic [7:0]           cnt_q, cnt_d;
  logic [QUAL_W-1:0]    qual_q, qual_d;
  logic                 stb_dly_q, stb_dly_d;
  logic [ACC_WIDTH-1:0] dly_q   [CHANNELS][STAGES];
  logic [ACC_WIDTH-1:0] dly_d   [CHANNELS][STAGES];
  logic [ACC_WIDTH-1:0] comb_q  [CHANNELS];
  logic [ACC_WIDTH-1:0] comb_d  [CHANNELS];
  logic [ACC_WIDTH-1:0] integ_q [CHANNELS][STAGES];
  logic [ACC_WIDTH-1:0] integ_d [CHANNELS][STAGES];
  logic [OUT_WIDTH-1:0] out_q   [CHANNELS];
  logic [OUT_WIDTH-1:0] out_d   [CHANNELS];

  // Reset is folded in so that no strobe is raised while reset is held.
  assign strobe_in  = enable & ~reset & (cnt_q == '0);
  assign strobe_out = enable & ~reset & (qual_q == QUAL_W'(QUAL_MAX));

  always_comb begin : ctrl_next
    cnt_d     = cnt_q;
    qual_d    = qual_q;
    stb_dly_d = strobe_in;
    if (!enable) begin
      cnt_d     = '0;
      qual_d    = '0;
      stb_dly_d = 1'b0;
    end else begin
      if (cnt_q == '0) begin
        cnt_d = (rate > 8'd1) ? rate - 8'd1 : '0;
      end else begin
        cnt_d = cnt_q - 8'd1;
      end
      if (qual_q != QUAL_W'(QUAL_MAX)) begin
        qual_d = qual_q + QUAL_W'(1);
      end
    end
  end

  always_comb begin : datapath_next
    logic [ACC_WIDTH-1:0]        acc;
    logic signed [EXT_WIDTH-1:0] v;
`ifdef CIC_INTERP_ROUND_EN
    logic signed [EXT_WIDTH-1:0] rnd;
`endif
    for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
      acc = {{(ACC_WIDTH-IN_WIDTH){signal_in[ch*IN_WIDTH + IN_WIDTH - 1]}},
             signal_in[ch*IN_WIDTH +: IN_WIDTH]};
      // Each delay holds its own stage input, so acc walks down the chain in place.
      for (int unsigned s = 0; s < STAGES; s++) begin
        dly_d[ch][s] = strobe_in ? acc : dly_q[ch][s];
        acc          = acc - dly_q[ch][s];
      end
      comb_d[ch] = strobe_in ? acc : comb_q[ch];

      integ_d[ch][0] = integ_q[ch][0] + (stb_dly_q ? comb_q[ch] : '0);
      for (int unsigned s = 1; s < STAGES; s++) begin
        integ_d[ch][s] = integ_q[ch][s] + integ_q[ch][s-1];
      end

      v = {integ_q[ch][STAGES-1][ACC_WIDTH-1], integ_q[ch][STAGES-1]};
`ifdef CIC_INTERP_ROUND_EN
      rnd = '0;
      if (shift != 6'd0) begin
        rnd = EXT_WIDTH'(1) << (shift - 6'd1);
      end
      v = v + rnd;
`endif
      v = v >>> shift;
      if (v > SAT_HI) begin
        out_d[ch] = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end else if (v < SAT_LO) begin
        out_d[ch] = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      end else begin
        out_d[ch] = v[OUT_WIDTH-1:0];
      end

      if (!enable) begin
        for (int unsigned s = 0; s < STAGES; s++) begin
          dly_d[ch][s]   = '0;
          integ_d[ch][s] = '0;
        end
        comb_d[ch] = '0;
        out_d[ch]  = '0;
      end
    end
  end

  always_comb begin : pack_out
    signal_out = '0;
    for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
      signal_out[ch*OUT_WIDTH +: OUT_WIDTH] = out_q[ch];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q     <= '0;
      qual_q    <= '0;
      stb_dly_q <= 1'b0;
      dly_q     <= '{default: '0};
      comb_q    <= '{default: '0};
      integ_q   <= '{default: '0};
      out_q     <= '{default: '0};
    end else begin
      cnt_q     <= cnt_d;
      qual_q    <= qual_d;
      stb_dly_q <= stb_dly_d;
      dly_q     <= dly_d;
      comb_q    <= comb_d;
      integ_q   <= integ_d;
      out_q     <= out_d;
    end
  end

endmodule
